ram_responder: RTL and testbench

Memory-side responder for the pipeline's cache management unit (CMU) memory port. It accepts one word request per chip-select handshake. It models a fixed, parameterised access latency and returns read data with a one-cycle acknowledge. It sits between the CMU's `mem_*` outputs and a synchronous word array, and reports its FSM state for the CPU test/debug display.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_array.sv | 39 +++
 rtl/ram_responder.sv | 137 +++++++++++++
 tb/tb_ram_responder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the CMU memory-side responder.
// Holds the FSM state encoding (also decoded by the CMU and the CPU
// test/debug display), the width of the debug state code, and the data width.
package ram_pkg;

    localparam int unsigned RAM_STATE_W = 3;
    localparam int unsigned DATA_W      = 32;

    typedef enum logic [RAM_STATE_W-1:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StWrite = 3'd2,
        StAck   = 3'd3
    } ram_state_e;

endpackage

// File: rtl/ram_array.sv
// ram_array: single-port synchronous word array with registered read.
// No reset, so it maps onto block RAM.
// Ports:
//   clk_i    clock
//   we_i     write enable: mem[addr_i] <= wdata_i
//   re_i     read enable: rdata_o <= mem[addr_i]; rdata_o holds otherwise
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  registered read data
module ram_array
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the CMU memory port.
// Accepts one word request per cs handshake in IDLE, stays busy for LATENCY
// cycles, then pulses ack for one cycle with read data valid on dout.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   cs, we     request valid and write select (sampled in IDLE only)
//   addr       byte address; word index = addr[ADDR_WIDTH+1:2]
//   din        write data (latched with the request)
//   dout       registered read data, held until the next read completes
//   ack        one-cycle completion pulse
//   stall      high while a request is being served
//   ram_state  FSM state code for the debug display
module ram_responder
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs,
    input  logic                   we,
    input  logic [31:0]            addr,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic                   ack,
    output logic                   stall,
    output logic [RAM_STATE_W-1:0] ram_state
);

    localparam int unsigned CNT_W = 4;

    ram_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     dout_q, dout_d;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  last_cycle;
    logic                  arr_we, arr_re;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_W-1:0]     arr_rdata;

    // Byte offset and bits above the array depth are ignored (addresses alias).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    assign req_idx    = addr[ADDR_WIDTH+1:2];
    assign last_cycle = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        dout_d   = dout_q;
        arr_we   = 1'b0;
        arr_re   = 1'b0;
        arr_addr = idx_q;

        unique case (state_q)
            StIdle: begin
                arr_addr = req_idx;
                if (cs) begin
                    idx_d   = req_idx;
                    wdata_d = din;
                    cnt_d   = CNT_W'(LATENCY);
                    // Start the array read at the sample edge so its registered
                    // output is ready even for LATENCY = 1; it holds until the
                    // next read since re is asserted only here.
                    arr_re  = ~we;
                    state_d = we ? StWrite : StRead;
                end
            end
            StRead: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last_cycle) begin
                    dout_d  = arr_rdata;
                    state_d = StAck;
                end
            end
            StWrite: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last_cycle) begin
                    arr_we  = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A pending write must be discarded when reset hits.
        if (rst) begin
            arr_we = 1'b0;
            arr_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
        end
    end

    ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram_array (
        .clk_i  (clk),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .addr_i (arr_addr),
        .wdata_i(wdata_q),
        .rdata_o(arr_rdata)
    );

    assign dout      = dout_q;
    assign ack       = (state_q == StAck);
    assign stall     = (state_q == StRead) || (state_q == StWrite);
    assign ram_state = state_q;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

    localparam int AW  = 10;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ack;
    logic        stall;
    logic [2:0]  ram_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: word store indexed by word number modulo depth, last read value.
    logic [31:0] mem_model [int];
    logic [31:0] dout_exp;
    int          written_idx [$];

    always #5 clk = ~clk;

    ram_responder #(
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .ack      (ack),
        .stall    (stall),
        .ram_state(ram_state)
    );

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << AW));
    endfunction

    // Issues one request from an idle responder (called at a negedge) and
    // reports what was observed. Returns at a negedge in the following IDLE cycle.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input bit mangle, output int lat, output int bad,
                           output logic [31:0] d_ack, output logic [2:0] st_ack);
        lat    = -1;
        bad    = 0;
        d_ack  = 'x;
        st_ack = 'x;
        cs   = 1'b1;
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        for (int n = 1; n <= LAT + 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cs = 1'b0;
                if (mangle) begin
                    addr = a + 32'd4;
                    din  = 32'd0;
                end
            end
            if (ack === 1'b1) begin
                lat    = n;
                d_ack  = dout;
                st_ack = ram_state;
                if (stall !== 1'b0) bad++;
                break;
            end
            if (stall !== 1'b1 || ram_state !== (w ? 3'd2 : 3'd1)) bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int acks;
        int busy;
        rst  = 1'b1;
        cs   = 1'b1;  // must be dropped while in reset
        we   = 1'b0;
        addr = 32'd0;
        din  = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cs  = 1'b0;
        dout_exp = 32'd0;
        n_cmp++;
        if ({ack, stall, ram_state} !== 5'd0 || dout !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: ack=%b stall=%b state=%0d dout=%h, want all 0",
                     ack, stall, ram_state, dout);
        end
        acks = 0;
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack !== 1'b0) acks++;
            if (ram_state !== 3'd0) busy++;
        end
        n_cmp++;
        if (acks !== 0 || busy !== 0) begin
            n_err++;
            $display("FAIL idle_no_ack: acks=%0d non_idle=%0d, want 0/0", acks, busy);
        end
    endtask

    task automatic test_write_read();
        int lat, bad;
        logic [31:0] d;
        logic [2:0] st;
        run_req(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat, bad, d, st);
        mem_model[widx(32'h10)] = 32'hDEAD_BEEF;
        n_cmp++;
        if (lat !== LAT + 1 || bad !== 0 || st !== 3'd3 || d !== dout_exp) begin
            n_err++;
            $display("FAIL write_0x10: lat=%0d bad=%0d st=%0d dout=%h, want lat=%0d bad=0 st=3 dout=%h",
                     lat, bad, st, d, LAT + 1, dout_exp);
        end
        run_req(1'b0, 32'h10, 32'h0, 1'b0, lat, bad, d, st);
        dout_exp = 32'hDEAD_BEEF;
        n_cmp++;
        if (lat !== LAT + 1 || bad !== 0 || st !== 3'd3 || d !== dout_exp) begin
            n_err++;
            $display("FAIL read_0x10: lat=%0d bad=%0d st=%0d dout=%h, want lat=%0d bad=0 st=3 dout=%h",
                     lat, bad, st, d, LAT + 1, dout_exp);
        end
    endtask

    task automatic test_latched();
        int lat, bad;
        logic [31:0] d;
        logic [2:0] st;
        run_req(1'b1, 32'h24, 32'hCAFE_F00D, 1'b0, lat, bad, d, st);
        mem_model[9] = 32'hCAFE_F00D;
        run_req(1'b1, 32'h20, 32'h1234_5678, 1'b1, lat, bad, d, st);
        mem_model[8] = 32'h1234_5678;
        n_cmp++;
        if (lat !== LAT + 1 || bad !== 0) begin
            n_err++;
            $display("FAIL latched_write_timing: lat=%0d bad=%0d, want %0d/0", lat, bad, LAT + 1);
        end
        run_req(1'b0, 32'h20, 32'h0, 1'b0, lat, bad, d, st);
        dout_exp = mem_model[8];
        n_cmp++;
        if (d !== dout_exp) begin
            n_err++;
            $display("FAIL latched_word8: got %h want %h", d, dout_exp);
        end
        run_req(1'b0, 32'h24, 32'h0, 1'b0, lat, bad, d, st);
        dout_exp = mem_model[9];
        n_cmp++;
        if (d !== dout_exp) begin
            n_err++;
            $display("FAIL latched_word9: got %h want %h", d, dout_exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bad, k, cyc, last;
        logic [31:0] d;
        logic [2:0] st;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            v = $urandom;
            run_req(1'b1, 32'(4 * i), v, 1'b0, lat, bad, d, st);
            mem_model[i] = v;
        end
        cs   = 1'b1;
        we   = 1'b0;
        addr = 32'h0;
        k    = 0;
        cyc  = 0;
        last = 0;
        @(posedge clk);
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack === 1'b1) begin
                n_cmp++;
                if ((cyc - last) !== (k == 0 ? LAT + 1 : LAT + 2) || dout !== mem_model[k]) begin
                    n_err++;
                    $display("FAIL b2b_ack%0d: gap=%0d dout=%h, want gap=%0d dout=%h", k,
                             cyc - last, dout, (k == 0 ? LAT + 1 : LAT + 2), mem_model[k]);
                end
                last = cyc;
                k++;
                addr = 32'(4 * k);
                if (k == 4) cs = 1'b0;
            end
        end
        cs = 1'b0;
        n_cmp++;
        if (k !== 4) begin
            n_err++;
            $display("FAIL b2b_count: acks=%0d want 4", k);
        end
        dout_exp = mem_model[3];
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int lat, bad, acks;
        logic [31:0] d;
        logic [2:0] st;
        run_req(1'b1, 32'h30, 32'h1111_2222, 1'b0, lat, bad, d, st);
        mem_model[12] = 32'h1111_2222;
        cs   = 1'b1;
        we   = 1'b1;
        addr = 32'h30;
        din  = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dout_exp = 32'd0;
        n_cmp++;
        if (ram_state !== 3'd0 || stall !== 1'b0 || dout !== dout_exp) begin
            n_err++;
            $display("FAIL midreset_state: state=%0d stall=%b dout=%h, want 0/0/0",
                     ram_state, stall, dout);
        end
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack !== 1'b0) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin
            n_err++;
            $display("FAIL midreset_no_ack: acks=%0d want 0", acks);
        end
        run_req(1'b0, 32'h30, 32'h0, 1'b0, lat, bad, d, st);
        dout_exp = mem_model[12];
        n_cmp++;
        if (d !== dout_exp || lat !== LAT + 1) begin
            n_err++;
            $display("FAIL midreset_old_value: dout=%h lat=%0d, want %h lat=%0d",
                     d, lat, dout_exp, LAT + 1);
        end
    endtask

    task automatic test_alias();
        int lat, bad;
        logic [31:0] d;
        logic [2:0] st;
        run_req(1'b1, 32'h1000, 32'h0000_00FF, 1'b0, lat, bad, d, st);
        mem_model[widx(32'h1000)] = 32'h0000_00FF;
        run_req(1'b0, 32'h0, 32'h0, 1'b0, lat, bad, d, st);
        dout_exp = mem_model[0];
        n_cmp++;
        if (d !== dout_exp) begin
            n_err++;
            $display("FAIL alias_read_0x0: got %h want %h", d, dout_exp);
        end
        run_req(1'b0, 32'h3, 32'h0, 1'b0, lat, bad, d, st);
        n_cmp++;
        if (d !== dout_exp) begin
            n_err++;
            $display("FAIL alias_read_0x3: got %h want %h", d, dout_exp);
        end
    endtask

    task automatic test_random();
        int lat, bad, idx;
        logic [31:0] d, a, v;
        logic [2:0] st;
        bit w;
        for (int i = 0; i < 24; i++) begin
            w = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            if (w) begin
                a = $urandom;
                v = $urandom;
                idx = widx(a);
                run_req(1'b1, a, v, 1'($urandom_range(0, 1)), lat, bad, d, st);
                mem_model[idx] = v;
                written_idx.push_back(idx);
            end else begin
                idx = written_idx[$urandom_range(0, written_idx.size() - 1)];
                a = ($urandom & ~32'h0000_0FFC) | (32'(idx) << 2);
                run_req(1'b0, a, $urandom, 1'b0, lat, bad, d, st);
                dout_exp = mem_model[idx];
            end
            n_cmp++;
            if (lat !== LAT + 1 || bad !== 0 || st !== 3'd3 || d !== dout_exp) begin
                n_err++;
                $display("FAIL rand_%0d_%s a=%h: lat=%0d bad=%0d st=%0d dout=%h, want lat=%0d bad=0 st=3 dout=%h",
                         i, w ? "wr" : "rd", a, lat, bad, st, d, LAT + 1, dout_exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_latched();
        test_back_to_back();
        test_reset_mid_write();
        test_alias();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
